reg_pipe: RTL

Parametrised, flow-controlled register pipeline: DEPTH register stages of WIDTH bits, each carrying a valid bit, joined by a valid/ready handshake with bubble collapsing. It replaces the plain enable register wherever data must be retimed through several stages under back-pressure. It adds a global enable (freeze), a synchronous flush and an optional occupancy counter. It sits between any producer/consumer pair in the datapath.

---
 rtl/reg_pipe_pkg.sv | 11 +
 rtl/reg_pipe_stage.sv | 57 +++++
 rtl/reg_pipe.sv | 104 ++++++++++
 3 files changed

// File: rtl/reg_pipe_pkg.sv
// Shared constants and helpers for the reg_pipe flow-controlled register pipeline.
package reg_pipe_pkg;

    localparam int DEF_WIDTH = 7;
    localparam int DEF_DEPTH = 4;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline slot: valid bit plus data word, with clear > hold > load priority.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear_i,
    input  logic             hold_i,
    input  logic             load_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // Next-state selection; data only moves when the incoming slot is valid.
    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (clear_i) begin
            v_d = 1'b0;
        end else if (hold_i) begin
            v_d = v_q;
            d_d = d_q;
        end else if (load_i) begin
            v_d = valid_i;
            if (valid_i) begin
                d_d = data_i;
            end else begin
                d_d = d_q;
            end
        end else begin
            v_d = v_q;
            d_d = d_q;
        end
    end

    // Stage registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q <= 1'b0;
            d_q <= {WIDTH{1'b0}};
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign valid_o = v_q;
    assign data_o  = d_q;

endmodule

// File: rtl/reg_pipe.sv
// DEPTH-stage valid/ready register pipeline with bubble collapsing, freeze and flush.
// Optional occupancy counter port enabled by defining REG_PIPE_OCC_EN.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      en,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready
`ifdef REG_PIPE_OCC_EN
    ,
    output logic [occ_w(DEPTH)-1:0]   occ
`endif
);

    logic             active_s;
    logic [DEPTH-1:0] v_s;
    logic [DEPTH-1:0] r_s;
    logic [WIDTH-1:0] d_s [DEPTH];

    assign active_s = en & ~flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             pv_s;
            logic [WIDTH-1:0] pd_s;

            if (gi == 0) begin : g_first
                assign pv_s = in_valid;
                assign pd_s = in_data;
            end else begin : g_next
                assign pv_s = v_s[gi-1];
                assign pd_s = d_s[gi-1];
            end

            // A stage can take a word unless it and everything downstream is full and stalled.
            assign r_s[gi] = out_ready | ~(&v_s[DEPTH-1:gi]);

            reg_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clk     (clk),
                .reset_n (reset_n),
                .clear_i (flush),
                .hold_i  (~en),
                .load_i  (r_s[gi]),
                .valid_i (pv_s),
                .data_i  (pd_s),
                .valid_o (v_s[gi]),
                .data_o  (d_s[gi])
            );
        end
    endgenerate

    assign in_ready  = active_s & r_s[0];
    assign out_valid = active_s & v_s[DEPTH-1];
    assign out_data  = d_s[DEPTH-1];

`ifdef REG_PIPE_OCC_EN
    localparam int OW = occ_w(DEPTH);

    logic [OW-1:0] occ_q, occ_d;
    logic          in_xfer_s, out_xfer_s;

    assign in_xfer_s  = in_valid & in_ready;
    assign out_xfer_s = out_valid & out_ready;

    // Occupancy tracks accepted minus delivered words.
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = {OW{1'b0}};
        end else if (en) begin
            case ({in_xfer_s, out_xfer_s})
                2'b10:   occ_d = occ_q + OW'(1'b1);
                2'b01:   occ_d = occ_q - OW'(1'b1);
                default: occ_d = occ_q;
            endcase
        end else begin
            occ_d = occ_q;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            occ_q <= {OW{1'b0}};
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
`endif

endmodule
